piso_tx: RTL and testbench

//  Parallel-in/serial-out transmitter. Feeds the 4-bit SIPO shift register stage directly.

---
 rtl/piso_tx_pkg.sv | 17 +
 rtl/piso_tx_bit_counter.sv | 33 +++
 rtl/piso_tx.sv | 133 +++++++++++++
 tb/tb_piso_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter:
// FSM state encoding and the counter-width helper.
package piso_tx_pkg;

    // FSM states; encodings are fixed so downstream debug tools can decode them
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Bounded up-counter: counts 0..MAX-1 while enabled, saturates at its
// terminal value (never wraps), synchronous clear has priority over enable.
module piso_tx_bit_counter #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    logic [W-1:0] r_cnt;
    logic         w_term;

    assign w_term = (r_cnt == W'(MAX - 1));
    assign o_term = w_term;

    // Count register: clear wins, then saturating increment
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_term) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a
// valid/ready handshake and shifts it out LSB-first, one bit per clock,
// with sout_valid framing, a done pulse and optional idle gap cycles.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_done;

    logic w_bit_term;
    logic w_gap_term;
    logic w_last;
    logic w_ready;
    logic w_xfer;
    logic w_bit_en;
    logic w_gap_en;

    // Last data bit is on the line when the bit counter reaches WIDTH-1
    assign w_last   = (r_state == ST_SHIFT) && w_bit_term;

    // Ready in IDLE, and in the last bit cycle only when streaming back-to-back;
    // held low throughout reset so no word can slip in
    assign w_ready  = !rst && ((r_state == ST_IDLE) || ((GAP == 0) && w_last));
    assign w_xfer   = din_valid && w_ready;

    assign w_bit_en = (r_state == ST_SHIFT);
    assign w_gap_en = (r_state == ST_GAP);

    // Outputs are decoded only from registers; sout is gated so it idles low
    assign din_ready  = w_ready;
    assign sout_valid = (r_state == ST_SHIFT);
    assign sout       = (r_state == ST_SHIFT) && r_shreg[0];
    assign done       = r_done;

    piso_tx_bit_counter #(
        .MAX (WIDTH),
        .W   (CNT_W)
    ) u_bit_cnt (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_xfer),
        .i_en   (w_bit_en),
        .o_term (w_bit_term)
    );

    generate
        if (GAP > 0) begin : g_gap
            localparam int GAP_W = cnt_w(GAP + 1);

            piso_tx_bit_counter #(
                .MAX (GAP),
                .W   (GAP_W)
            ) u_gap_cnt (
                .i_clk  (clk),
                .i_rst  (rst),
                .i_clr  (w_last),
                .i_en   (w_gap_en),
                .o_term (w_gap_term)
            );
        end else begin : g_no_gap
            assign w_gap_term = 1'b1;
        end
    endgenerate

    // Transmit FSM with shift register and registered done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_shreg <= din;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        if (GAP == 0) begin
                            if (w_xfer) begin
                                // Reload without a bubble cycle
                                r_shreg <= din;
                                r_state <= ST_SHIFT;
                            end else begin
                                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                        r_state <= ST_SHIFT;
                    end
                end
                ST_GAP: begin
                    if (w_gap_term) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_shreg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench: piso_tx (GAP=0 and GAP=2) each feeding a 4-bit SIPO model.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] din0, din2;
    logic       valid0, valid2;
    logic       ready0, ready2;
    logic       sout0, sout2;
    logic       sval0, sval2;
    logic       done0, done2;

    logic [3:0] q0, q2;
    logic [3:0] w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(valid0), .din_ready(ready0),
        .sout(sout0), .sout_valid(sval0), .done(done0)
    );

    piso_tx #(.WIDTH(4), .GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(valid2), .din_ready(ready2),
        .sout(sout2), .sout_valid(sval2), .done(done2)
    );

    // Downstream SIPO models: first bit enters at q[3] and moves toward q[0]
    always_ff @(posedge clk) begin
        q0 <= {sout0, q0[3:1]};
        q2 <= {sout2, q2[3:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, with din_valid offered during reset
        rst = 1'b1; din0 = 4'b1111; valid0 = 1'b1; din2 = 4'b1111; valid2 = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready0", ready0, 4'd0);
            chk("rst_sval0",  sval0,  4'd0);
            chk("rst_sout0",  sout0,  4'd0);
            chk("rst_done0",  done0,  4'd0);
            chk("rst_ready2", ready2, 4'd0);
            chk("rst_sval2",  sval2,  4'd0);
            tick();
        end
        valid0 = 1'b0; valid2 = 1'b0; rst = 1'b0;
        tick();
        chk("rst_no_xfer0", sval0, 4'd0);
        chk("rst_no_xfer2", sval2, 4'd0);
        chk("post_rst_ready0", ready0, 4'd1);

        // Single word, GAP=0
        din0 = 4'b1011; valid0 = 1'b1;
        chk("t1_ready", ready0, 4'd1);
        tick();
        valid0 = 1'b0;
        w = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            chk("t1_sval", sval0, 4'd1);
            chk("t1_sout", sout0, {3'd0, w[k]});
            chk("t1_done_low", done0, 4'd0);
            chk("t1_ready_shift", ready0, (k == 3) ? 4'd1 : 4'd0);
            tick();
        end
        chk("t1_done", done0, 4'd1);
        chk("t1_q", q0, 4'b1011);
        chk("t1_sval_end", sval0, 4'd0);
        chk("t1_sout_end", sout0, 4'd0);
        tick();
        chk("t1_done_pulse", done0, 4'd0);

        // Back-to-back, GAP=0
        din0 = 4'b0110; valid0 = 1'b1;
        tick();
        din0 = 4'b1001;
        w = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            chk("t2_sval_a", sval0, 4'd1);
            chk("t2_sout_a", sout0, {3'd0, w[k]});
            chk("t2_done_a", done0, 4'd0);
            tick();
        end
        valid0 = 1'b0;
        chk("t2_done_1", done0, 4'd1);
        chk("t2_q_1", q0, 4'b0110);
        w = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            chk("t2_sval_b", sval0, 4'd1);
            chk("t2_sout_b", sout0, {3'd0, w[k]});
            if (k > 0) chk("t2_done_b", done0, 4'd0);
            tick();
        end
        chk("t2_done_2", done0, 4'd1);
        chk("t2_q_2", q0, 4'b1001);
        chk("t2_sval_end", sval0, 4'd0);
        tick();

        // Busy stall: changing din while not ready must not disturb the word
        din0 = 4'b0010; valid0 = 1'b1;
        tick();
        din0 = 4'b1111;
        w = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            chk("t4_sout", sout0, {3'd0, w[k]});
            chk("t4_ready", ready0, (k == 3) ? 4'd1 : 4'd0);
            tick();
        end
        valid0 = 1'b0;
        chk("t4_done_1", done0, 4'd1);
        chk("t4_q_1", q0, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            chk("t4_sout_b", sout0, 4'd1);
            tick();
        end
        chk("t4_done_2", done0, 4'd1);
        chk("t4_q_2", q0, 4'b1111);
        tick();

        // Reset mid-word
        din0 = 4'b1100; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        chk("t5_bit0", sout0, 4'd0);
        tick();
        chk("t5_bit1", sout0, 4'd0);
        tick();
        chk("t5_bit2", sout0, 4'd1);
        rst = 1'b1; din0 = 4'b1111; valid0 = 1'b1;
        #1;
        chk("t5_rst_sout", sout0, 4'd0);
        chk("t5_rst_sval", sval0, 4'd0);
        chk("t5_rst_done", done0, 4'd0);
        chk("t5_rst_ready", ready0, 4'd0);
        tick();
        chk("t5_rst_done_b", done0, 4'd0);
        chk("t5_rst_ready_b", ready0, 4'd0);
        rst = 1'b0; valid0 = 1'b0;
        tick();
        chk("t5_no_done", done0, 4'd0);
        chk("t5_idle_sval", sval0, 4'd0);
        din0 = 4'b0101; valid0 = 1'b1;
        chk("t5_ready", ready0, 4'd1);
        tick();
        valid0 = 1'b0;
        w = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            chk("t5_sout", sout0, {3'd0, w[k]});
            tick();
        end
        chk("t5_done", done0, 4'd1);
        chk("t5_q", q0, 4'b0101);

        // GAP=2 instance: two idle cycles between words
        din2 = 4'b0110; valid2 = 1'b1;
        chk("t3_ready0", ready2, 4'd1);
        tick();
        din2 = 4'b1001;
        w = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            chk("t3_sval_a", sval2, 4'd1);
            chk("t3_sout_a", sout2, {3'd0, w[k]});
            chk("t3_ready_a", ready2, 4'd0);
            tick();
        end
        chk("t3_done_1", done2, 4'd1);
        chk("t3_q_1", q2, 4'b0110);
        chk("t3_gap1_sval", sval2, 4'd0);
        chk("t3_gap1_ready", ready2, 4'd0);
        tick();
        chk("t3_gap2_sval", sval2, 4'd0);
        chk("t3_gap2_ready", ready2, 4'd0);
        chk("t3_gap2_done", done2, 4'd0);
        tick();
        chk("t3_idle_ready", ready2, 4'd1);
        chk("t3_idle_sval", sval2, 4'd0);
        tick();
        valid2 = 1'b0;
        w = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            chk("t3_sval_b", sval2, 4'd1);
            chk("t3_sout_b", sout2, {3'd0, w[k]});
            tick();
        end
        chk("t3_done_2", done2, 4'd1);
        chk("t3_q_2", q2, 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
